// File: rtl/coin_payout_ctrl.sv
// Change-payout controller: pays a cent amount out as quarters, dimes and nickels.
// Each ejected coin is confirmed by the hopper exit sensor, and the coin inventory is tracked.
module coin_payout_ctrl #(
    parameter int unsigned AMT_W     = 7,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_quarters,
    input  logic [CNT_W-1:0] load_dimes,
    input  logic [CNT_W-1:0] load_nickels,
    input  logic             coin_sensed,
    output logic             eject_quarter,
    output logic             eject_dime,
    output logic             eject_nickel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] paid_amount,
    output logic [CNT_W-1:0] inv_quarters,
    output logic [CNT_W-1:0] inv_dimes,
    output logic [CNT_W-1:0] inv_nickels
);

    localparam int unsigned TMR_MAX = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_EMPTY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SELECT,
        S_EJECT,
        S_WAIT,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    state_t           state, state_nx;
    coin_t            sel, sel_nx;
    logic [AMT_W-1:0] remaining, rem_nx;
    logic [AMT_W-1:0] paid_nx;
    logic [CNT_W-1:0] invq_nx, invd_nx, invn_nx;
    logic [1:0]       code_nx;
    logic             err_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             sensed, sensed_nx;
    logic             credit;
    logic [AMT_W-1:0] coin_val;

    // Value of the coin currently being paid out.
    always_comb begin
        coin_val = '0;
        case (sel)
            COIN_Q:  coin_val = AMT_W'(25);
            COIN_D:  coin_val = AMT_W'(10);
            COIN_N:  coin_val = AMT_W'(5);
            default: coin_val = '0;
        endcase
    end

    // Ready only while idle and not being loaded; a load takes priority over a request.
    assign req_ready = (state == S_IDLE) && !load_en;

    // Next-state and datapath update.
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        rem_nx    = remaining;
        paid_nx   = paid_amount;
        invq_nx   = inv_quarters;
        invd_nx   = inv_dimes;
        invn_nx   = inv_nickels;
        code_nx   = err_code;
        err_nx    = err;
        tmr_nx    = tmr;
        sensed_nx = sensed;
        credit    = 1'b0;

        case (state)
            S_IDLE: begin
                tmr_nx    = '0;
                sensed_nx = 1'b0;
                if (load_en) begin
                    invq_nx = load_quarters;
                    invd_nx = load_dimes;
                    invn_nx = load_nickels;
                end else if (req_valid) begin
                    rem_nx   = req_amount;
                    paid_nx  = '0;
                    err_nx   = 1'b0;
                    code_nx  = ERR_NONE;
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((remaining % AMT_W'(5)) != '0) begin
                    code_nx  = ERR_ALIGN;
                    state_nx = S_FIN;
                end else begin
                    state_nx = S_SELECT;
                end
            end
            S_SELECT: begin
                tmr_nx    = '0;
                sensed_nx = 1'b0;
                if (remaining == '0) begin
                    state_nx = S_FIN;
                end else if (remaining >= AMT_W'(25) && inv_quarters != '0) begin
                    sel_nx   = COIN_Q;
                    state_nx = S_EJECT;
                end else if (remaining >= AMT_W'(10) && inv_dimes != '0) begin
                    sel_nx   = COIN_D;
                    state_nx = S_EJECT;
                end else if (inv_nickels != '0) begin
                    sel_nx   = COIN_N;
                    state_nx = S_EJECT;
                end else begin
                    code_nx  = ERR_EMPTY;
                    state_nx = S_FIN;
                end
            end
            S_EJECT: begin
                // A coin sensed during the strobe is credited once; the strobe still runs full length.
                if (coin_sensed && !sensed) begin
                    credit    = 1'b1;
                    sensed_nx = 1'b1;
                end
                if (tmr == TMR_W'(PULSE_LEN - 1)) begin
                    tmr_nx   = '0;
                    state_nx = (sensed || coin_sensed) ? S_SELECT : S_WAIT;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
            end
            S_WAIT: begin
                if (coin_sensed) begin
                    credit   = 1'b1;
                    state_nx = S_SELECT;
                end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    code_nx  = ERR_TIMEOUT;
                    state_nx = S_FIN;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Account for a confirmed coin.
        if (credit) begin
            rem_nx  = remaining - coin_val;
            paid_nx = paid_amount + coin_val;
            case (sel)
                COIN_Q:  invq_nx = inv_quarters - CNT_W'(1);
                COIN_D:  invd_nx = inv_dimes - CNT_W'(1);
                COIN_N:  invn_nx = inv_nickels - CNT_W'(1);
                default: ;
            endcase
        end

        // Error flag becomes visible together with the done pulse.
        if (state_nx == S_FIN) begin
            err_nx = (code_nx != ERR_NONE);
        end
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            sel           <= COIN_NONE;
            remaining     <= '0;
            paid_amount   <= '0;
            inv_quarters  <= '0;
            inv_dimes     <= '0;
            inv_nickels   <= '0;
            err_code      <= ERR_NONE;
            err           <= 1'b0;
            tmr           <= '0;
            sensed        <= 1'b0;
            eject_quarter <= 1'b0;
            eject_dime    <= 1'b0;
            eject_nickel  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            sel           <= sel_nx;
            remaining     <= rem_nx;
            paid_amount   <= paid_nx;
            inv_quarters  <= invq_nx;
            inv_dimes     <= invd_nx;
            inv_nickels   <= invn_nx;
            err_code      <= code_nx;
            err           <= err_nx;
            tmr           <= tmr_nx;
            sensed        <= sensed_nx;
            eject_quarter <= (state_nx == S_EJECT) && (sel_nx == COIN_Q);
            eject_dime    <= (state_nx == S_EJECT) && (sel_nx == COIN_D);
            eject_nickel  <= (state_nx == S_EJECT) && (sel_nx == COIN_N);
            busy          <= (state_nx != S_IDLE);
            done          <= (state_nx == S_FIN);
        end
    end

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// Directed bench for coin_payout_ctrl with a sensor responder and strobe monitor.
module tb_coin_payout_ctrl;

    localparam int unsigned AMT_W = 7;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic             load_en;
    logic [CNT_W-1:0] load_quarters, load_dimes, load_nickels;
    logic             coin_sensed;
    logic             eject_quarter, eject_dime, eject_nickel;
    logic             busy, done, err;
    logic [1:0]       err_code;
    logic [AMT_W-1:0] paid_amount;
    logic [CNT_W-1:0] inv_quarters, inv_dimes, inv_nickels;

    int errors = 0;
    int checks = 0;

    // Monitor state (written only by the monitor process).
    logic    sense_en = 1'b0;
    int      seq, n_strobes, ej_cycles, n_done, multi_hot;
    logic [2:0] prev_ej;
    logic    prev_busy;

    coin_payout_ctrl #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_LEN(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
        .load_en(load_en), .load_quarters(load_quarters), .load_dimes(load_dimes),
        .load_nickels(load_nickels), .coin_sensed(coin_sensed),
        .eject_quarter(eject_quarter), .eject_dime(eject_dime), .eject_nickel(eject_nickel),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .paid_amount(paid_amount), .inv_quarters(inv_quarters),
        .inv_dimes(inv_dimes), .inv_nickels(inv_nickels)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe monitor and sensor responder: pulses coin_sensed the cycle after a strobe ends.
    initial begin
        logic [2:0] ej;
        coin_sensed = 1'b0;
        prev_ej = 3'b000;
        prev_busy = 1'b0;
        seq = 0; n_strobes = 0; ej_cycles = 0; n_done = 0; multi_hot = 0;
        forever begin
            @(negedge clk);
            ej = {eject_quarter, eject_dime, eject_nickel};
            if (busy && !prev_busy) begin
                seq = 0; n_strobes = 0; ej_cycles = 0; n_done = 0;
            end
            if (ej != 3'b000 && prev_ej == 3'b000) begin
                n_strobes++;
                seq = seq * 4 + (ej[2] ? 1 : ej[1] ? 2 : 3);
            end
            if (ej != 3'b000) ej_cycles++;
            if ($countones(ej) > 1) multi_hot++;
            if (done) n_done++;
            coin_sensed = sense_en && (prev_ej != 3'b000) && (ej == 3'b000);
            prev_ej = ej;
            prev_busy = busy;
        end
    end

    task automatic do_load(input int q, input int d, input int n);
        load_en = 1'b1;
        load_quarters = CNT_W'(q);
        load_dimes = CNT_W'(d);
        load_nickels = CNT_W'(n);
        #1 check("ready_low_on_load", req_ready, 0);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic start_req(input int amt);
        req_valid = 1'b1;
        req_amount = AMT_W'(amt);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits for done; cyc is the cycle number counted from the accept edge.
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        req_valid = 1'b0;
        req_amount = '0;
        load_en = 1'b0;
        load_quarters = '0; load_dimes = '0; load_nickels = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_paid", paid_amount, 0);
        check("rst_inv", {inv_quarters, inv_dimes, inv_nickels}, 0);

        // 40 cents: quarter, dime, nickel
        do_load(2, 2, 2);
        check("load_inv", {inv_quarters, inv_dimes, inv_nickels}, {8'd2, 8'd2, 8'd2});
        sense_en = 1'b1;
        start_req(40);
        wait_done(1, cyc);
        check("t40_latency", cyc, 15);
        check("t40_err", err, 0);
        check("t40_code", err_code, 0);
        check("t40_paid", paid_amount, 40);
        @(negedge clk);
        check("t40_order", seq, 27);
        check("t40_strobes", n_strobes, 3);
        check("t40_strobe_cycles", ej_cycles, 6);
        check("t40_done_count", n_done, 1);
        check("t40_inv", {inv_quarters, inv_dimes, inv_nickels}, {8'd1, 8'd1, 8'd1});
        check("t40_idle", {busy, req_ready}, 2'b01);

        // 12 cents: not a multiple of 5
        start_req(12);
        wait_done(1, cyc);
        check("t12_latency", cyc, 2);
        check("t12_err", err, 1);
        check("t12_code", err_code, 1);
        check("t12_paid", paid_amount, 0);
        @(negedge clk);
        check("t12_strobes", n_strobes, 0);
        check("t12_inv", {inv_quarters, inv_dimes, inv_nickels}, {8'd1, 8'd1, 8'd1});

        // 15 cents with a single nickel: inventory exhausted after one coin
        do_load(0, 0, 1);
        start_req(15);
        wait_done(1, cyc);
        check("t15_latency", cyc, 7);
        check("t15_err", err, 1);
        check("t15_code", err_code, 2);
        check("t15_paid", paid_amount, 5);
        @(negedge clk);
        check("t15_order", seq, 3);
        check("t15_inv_n", inv_nickels, 0);

        // 25 cents with sensor silent: timeout
        sense_en = 1'b0;
        do_load(1, 0, 0);
        start_req(25);
        wait_done(1, cyc);
        check("t25_latency", cyc, 21);
        check("t25_code", err_code, 3);
        check("t25_err", err, 1);
        check("t25_paid", paid_amount, 0);
        @(negedge clk);
        check("t25_strobe_cycles", ej_cycles, 2);
        check("t25_inv_q", inv_quarters, 1);

        // Reset during WAIT of a dime payout
        do_load(0, 1, 0);
        start_req(10);
        repeat (5) @(negedge clk);
        check("rw_busy_wait", {busy, eject_dime}, 2'b10);
        reset = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_done", done, 0);
        check("rw_eject", {eject_quarter, eject_dime, eject_nickel}, 0);
        check("rw_paid", paid_amount, 0);
        repeat (2) @(negedge clk);
        check("rw_no_done", n_done, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rw_ready", req_ready, 1);
        check("rw_inv", {inv_quarters, inv_dimes, inv_nickels}, 0);

        // Request and load while busy are ignored
        sense_en = 1'b1;
        do_load(2, 2, 2);
        start_req(10);
        req_valid = 1'b1;
        req_amount = AMT_W'(25);
        load_en = 1'b1;
        load_quarters = 8'd9; load_dimes = 8'd9; load_nickels = 8'd9;
        #1 check("busy_ready", {busy, req_ready}, 2'b10);
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        load_en = 1'b0;
        wait_done(4, cyc);
        check("bz_latency", cyc, 7);
        check("bz_paid", paid_amount, 10);
        @(negedge clk);
        check("bz_order", seq, 2);
        check("bz_inv", {inv_quarters, inv_dimes, inv_nickels}, {8'd2, 8'd1, 8'd2});

        // Load and request together in IDLE: load wins
        load_en = 1'b1;
        req_valid = 1'b1;
        req_amount = AMT_W'(5);
        load_quarters = 8'd3; load_dimes = 8'd3; load_nickels = 8'd3;
        #1 check("lr_ready", req_ready, 0);
        @(negedge clk);
        load_en = 1'b0;
        req_valid = 1'b0;
        check("lr_inv", {inv_quarters, inv_dimes, inv_nickels}, {8'd3, 8'd3, 8'd3});
        check("lr_busy", busy, 0);
        @(negedge clk);
        check("lr_still_idle", {busy, req_ready}, 2'b01);
        check("one_hot_strobes", multi_hot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
